// File: rtl/receptor_uart_pkg.sv
// Shared definitions for the serial frame receiver: state encoding and frame geometry.
package receptor_uart_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned BITCNT_W   = 4;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        DADO      = 2'd1,
        INSTRUCAO = 2'd2,
        FIM       = 2'd3
    } estado_t;

endpackage

// File: rtl/receptor_uart.sv
// Serial frame receiver: start bit, 4 data bits, 4 instruction bits (LSB first), low trailer.
// Decoded pairs are held on a valid/ack interface with frame-error and overwrite flags.
module receptor_uart
    import receptor_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                info_entrada,
    input  logic                ack,
    output logic [NIBBLE_W-1:0] dado,
    output logic [NIBBLE_W-1:0] instrucao,
    output logic                valido,
    output logic                erro_quadro,
    output logic                sobrescrita
);

    localparam int unsigned      PER_W   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [PER_W-1:0] PER_ULT = PER_W'(CLKS_PER_BIT - 1);

    estado_t               estado;
    estado_t               estado_prox;
    logic [PER_W-1:0]      cnt_periodo;
    logic [BITCNT_W-1:0]   contador;
    logic [NIBBLE_W-1:0]   sh_dado;
    logic [NIBBLE_W-1:0]   sh_instr;

    logic fim_periodo_c;
    logic inicio_c;
    logic amostra_dado_c;
    logic amostra_instr_c;
    logic quadro_ok_c;
    logic quadro_err_c;

    assign fim_periodo_c = (cnt_periodo == PER_ULT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state and sampling strobes
    always_comb begin
        estado_prox     = estado;
        inicio_c        = 1'b0;
        amostra_dado_c  = 1'b0;
        amostra_instr_c = 1'b0;
        quadro_ok_c     = 1'b0;
        quadro_err_c    = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (!info_entrada) begin
                    estado_prox = DADO;
                    inicio_c    = 1'b1;
                end
            end
            DADO: begin
                if (fim_periodo_c) begin
                    amostra_dado_c = 1'b1;
                    if (contador == BITCNT_W'(NIBBLE_W - 1)) begin
                        estado_prox = INSTRUCAO;
                    end
                end
            end
            INSTRUCAO: begin
                if (fim_periodo_c) begin
                    amostra_instr_c = 1'b1;
                    if (contador == BITCNT_W'(FRAME_BITS - 1)) begin
                        estado_prox = FIM;
                    end
                end
            end
            FIM: begin
                if (fim_periodo_c) begin
                    estado_prox  = OCIOSO;
                    quadro_ok_c  = !info_entrada;
                    quadro_err_c = info_entrada;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // Bit-period counter idles at zero so start detection aligns the sampling phase
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_periodo <= '0;
        end else if (estado == OCIOSO || fim_periodo_c) begin
            cnt_periodo <= '0;
        end else begin
            cnt_periodo <= cnt_periodo + PER_W'(1);
        end
    end

    // Bit counter and shift registers; a fresh start discards any leftover bits
    always_ff @(posedge clk) begin
        if (rst) begin
            contador <= '0;
            sh_dado  <= '0;
            sh_instr <= '0;
        end else if (inicio_c) begin
            contador <= '0;
            sh_dado  <= '0;
            sh_instr <= '0;
        end else begin
            if (amostra_dado_c) begin
                sh_dado[contador[1:0]] <= info_entrada;
            end
            if (amostra_instr_c) begin
                sh_instr[contador[1:0]] <= info_entrada;
            end
            if (amostra_dado_c || amostra_instr_c) begin
                contador <= contador + BITCNT_W'(1);
            end
        end
    end

    // Hold interface: a completing good frame takes priority over ack
    always_ff @(posedge clk) begin
        if (rst) begin
            dado        <= '0;
            instrucao   <= '0;
            valido      <= 1'b0;
            erro_quadro <= 1'b0;
            sobrescrita <= 1'b0;
        end else begin
            erro_quadro <= quadro_err_c;
            if (quadro_ok_c) begin
                dado      <= sh_dado;
                instrucao <= sh_instr;
                valido    <= 1'b1;
                if (valido && !ack) begin
                    sobrescrita <= 1'b1;
                end
            end else if (valido && ack) begin
                valido <= 1'b0;
            end
        end
    end

endmodule

// File: doc/receptor_uart.md
# receptor_uart

Serial frame receiver, the counterpart of the team's button-triggered transmitter. It samples the single-wire line, detects the start bit, and shifts in 4 data bits then 4 instruction bits, both LSB first. It checks the trailing low bit and presents the decoded pair on a hold/acknowledge interface to the downstream instruction logic.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit. Must be ≥ 1. With 1 it matches the transmitter's one-bit-per-clock rate.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `info_entrada` in 1: serial line. Idle high, same clock domain as the transmitter, no synchronizer.
- `ack` in 1: consumer accepts the held frame. Sampled only while `valido`=1.
- `dado` out 4: last received data nibble.
- `instrucao` out 4: last received instruction nibble.
- `valido` out 1: held frame available. Held until `ack`.
- `erro_quadro` out 1: one-cycle pulse when a trailer bit is sampled high.
- `sobrescrita` out 1: sticky. Set when a good frame completes while `valido`=1. Cleared only by `rst`.

## Operation
- Frame on the line: start(0), d0..d3, i0..i3, trailer(0), then idle high. 10 bit periods in total.
- States:
  - OCIOSO: waits for `info_entrada`=0. Transitions to DADO and clears the bit counter.
  - DADO: shifts one sample per bit period into the data shift register at bit position `contador[1:0]`. After the 4th sample, goes to INSTRUCAO.
  - INSTRUCAO: same, into the instruction shift register. After the 8th overall sample, goes to FIM.
  - FIM: samples the trailer, then returns to OCIOSO unconditionally.
- Trailer = 0 (good frame):
  - Copy both shift registers to `dado` and `instrucao`.
  - Set `valido`.
  - If `valido` was already 1 and `ack` is not asserted on that edge, the new frame overwrites the old one and `sobrescrita` is set.
- Trailer = 1:
  - Pulse `erro_quadro`.
  - Outputs and `valido` are unchanged.
  - The shift registers are discarded.
- `ack`=1 with `valido`=1 clears `valido` on the next edge.
  - If a good frame completes on the same edge, that frame wins: `valido` stays 1, outputs update, and `sobrescrita` is not set.
- `ack` while `valido`=0 is ignored.
- Bit-period counter (width clog2(CLKS_PER_BIT)+1) runs only outside OCIOSO.
  - A sample is taken when the counter reaches CLKS_PER_BIT−1, then the counter reloads to 0.
  - In OCIOSO the start detection itself aligns the counter to 0.
- Bit counter: 4 bits, counting 0..8. It does not wrap, because FIM always exits to OCIOSO.
- Bits beyond a frame are not buffered. A start bit arriving during FIM is missed.

## Timing
- Reset values (registered on the first `clk` edge with `rst`=1):
  - state OCIOSO
  - `dado`=0, `instrucao`=0
  - `valido`=0, `erro_quadro`=0, `sobrescrita`=0
  - all counters 0
- Reset mid-frame aborts the frame. No output pulse results from the partial frame.
- With CLKS_PER_BIT=1 and the start bit sampled at edge S:
  - d0 is sampled at S+1, and d3 at S+4.
  - i0 is sampled at S+5, and i3 at S+8.
  - The trailer is sampled at S+9.
  - `valido` and the new `dado`/`instrucao` are visible after edge S+9.
  - Latency is 9 cycles from start-bit sample to output.
- General case: the trailer is sampled at S + 9·CLKS_PER_BIT.
- `erro_quadro` is high exactly one cycle, following the trailer edge.
- OCIOSO is re-entered after the trailer edge. A line low on the very next edge is treated as a new start.

## Structure
- Shared package holds:
  - the state encoding: OCIOSO, DADO, INSTRUCAO, FIM, as a 2-bit typedef
  - the constants NIBBLE_W=4 and FRAME_BITS=8
- No sub-modules. A single FSM plus datapath is the natural partitioning.
- The bit-period counter stays inline and is not worth a separate module.

## Test plan
- Reset, then one frame dado=4'hA, instrucao=4'h5, CLKS_PER_BIT=1 → `valido`=1 after edge S+9, `dado`=A, `instrucao`=5, `erro_quadro`=0.
- Frame with the trailer forced to 1 → `erro_quadro` pulses one cycle, `valido` stays 0, outputs stay 0.
- Two good frames (3/C, then 7/1) with no `ack` → second values held, `sobrescrita`=1. Then `ack` → `valido`=0 and `sobrescrita` stays 1.
- `ack` asserted on the same edge a frame 6/9 completes → `valido`=1, outputs 6/9, `sobrescrita`=0.
- `rst` asserted at S+4 of a frame, then released → all outputs 0. A following clean frame F/0 decodes correctly.
- CLKS_PER_BIT=4, frame 9/E with each bit held 4 cycles → `valido` after S+36, outputs 9/E.
